// File: rtl/axi_lite_master_multi.sv
// AXI4-Lite master moving a TXN_NUM-word vector between the unified
// buffer datapath and off-chip memory.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   mode, txn_en      : instruction request (00 idle, 01 load,
//                       10 write, 11 copy), held until inst_done
//   off_mem_addra/b   : write / read base addresses
//   wdata, rdata      : packed word vectors, word k at [k*DW +: DW]
//   inst_done         : instruction complete, held while txn_en
//   error, timeout    : sticky status of the current instruction
//   m_axi_*           : AXI4-Lite master channels (aw, w, b, ar, r)
module axi_lite_master_multi #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TXN_NUM        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [1:0]                    mode,
   input  logic                          txn_en,
   input  logic [ADDR_WIDTH-1:0]         off_mem_addra,
   input  logic [ADDR_WIDTH-1:0]         off_mem_addrb,
   input  logic [DATA_WIDTH*TXN_NUM-1:0] wdata,
   output logic [DATA_WIDTH*TXN_NUM-1:0] rdata,
   output logic                          inst_done,
   output logic                          error,
   output logic                          timeout,
   output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [DATA_WIDTH-1:0]         m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);

   localparam int DW = DATA_WIDTH;
   localparam int VW = DATA_WIDTH * TXN_NUM;
   localparam int CW = (TXN_NUM > 1) ? $clog2(TXN_NUM) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] M_NONE  = 2'b00;
   localparam logic [1:0] M_LOAD  = 2'b01;
   localparam logic [1:0] M_WRITE = 2'b10;
   localparam logic [1:0] M_COPY  = 2'b11;

   localparam logic [CW-1:0] LAST = CW'(TXN_NUM - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DW / 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_ADDR_DATA,
      S_WR_RESP,
      S_DONE
   } state_t;

   state_t                  state_q;
   logic [1:0]              mode_q;
   logic [CW-1:0]           cnt_q;
   logic [TW-1:0]           tmo_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [ADDR_WIDTH-1:0]   araddr_q;
   logic [VW-1:0]           wvec_q;
   logic [VW-1:0]           rvec_q;
   logic [DW-1:0]           wbeat_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic                    bready_q;
   logic                    arvalid_q;
   logic                    rready_q;
   logic                    done_q;
   logic                    error_q;
   logic                    timeout_q;

   logic                    adv_d;
   logic                    wait_d;
   logic                    tmo_hit_d;
   logic [CW-1:0]           nxt_d;
   logic [VW-1:0]           src_d;

   // adv_d: the handshake the current state waits on completes now.
   // In WR_ADDR_DATA a channel that already handshaked counts as done.
   always_comb begin
      nxt_d  = cnt_q + 1'b1;
      src_d  = (mode_q == M_COPY) ? rvec_q : wvec_q;
      adv_d  = 1'b0;
      wait_d = 1'b1;
      unique case (state_q)
         S_RD_ADDR:      adv_d = m_axi_arready;
         S_RD_DATA:      adv_d = m_axi_rvalid;
         S_WR_ADDR_DATA: adv_d = (!awvalid_q || m_axi_awready)
                               && (!wvalid_q || m_axi_wready);
         S_WR_RESP:      adv_d = m_axi_bvalid;
         default:        wait_d = 1'b0;
      endcase
      tmo_hit_d = wait_d && !adv_d && (tmo_q == TMO_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mode_q    <= M_NONE;
         cnt_q     <= '0;
         tmo_q     <= '0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wvec_q    <= '0;
         rvec_q    <= '0;
         wbeat_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else if (tmo_hit_d) begin
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         timeout_q <= 1'b1;
         error_q   <= 1'b1;
         done_q    <= 1'b1;
         state_q   <= S_DONE;
      end else begin
         // wait counter restarts whenever a state is (re)entered
         if (wait_d) begin
            tmo_q <= adv_d ? '0 : tmo_q + 1'b1;
         end
         unique case (state_q)
            S_IDLE: begin
               if (txn_en && !done_q) begin
                  mode_q    <= mode;
                  awaddr_q  <= off_mem_addra;
                  araddr_q  <= off_mem_addrb;
                  wvec_q    <= wdata;
                  cnt_q     <= '0;
                  tmo_q     <= '0;
                  error_q   <= 1'b0;
                  timeout_q <= 1'b0;
                  unique case (mode)
                     M_NONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                     M_WRITE: begin
                        wbeat_q   <= wdata[DW-1:0];
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WR_ADDR_DATA;
                     end
                     M_LOAD, M_COPY: begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RD_ADDR;
                     end
                  endcase
               end
            end
            S_RD_ADDR: begin
               if (adv_d) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (adv_d) begin
                  rready_q <= 1'b0;
                  rvec_q[cnt_q*DW +: DW] <= m_axi_rdata;
                  if (m_axi_rresp != 2'b00) error_q <= 1'b1;
                  if (cnt_q == LAST) begin
                     cnt_q <= '0;
                     if (mode_q == M_COPY) begin
                        // word 0 may be the beat landing right now
                        wbeat_q <= (TXN_NUM == 1) ? m_axi_rdata
                                                  : rvec_q[DW-1:0];
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WR_ADDR_DATA;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                  end else begin
                     cnt_q     <= nxt_d;
                     araddr_q  <= araddr_q + STEP;
                     arvalid_q <= 1'b1;
                     state_q   <= S_RD_ADDR;
                  end
               end
            end
            S_WR_ADDR_DATA: begin
               if (m_axi_awready) awvalid_q <= 1'b0;
               if (m_axi_wready) wvalid_q <= 1'b0;
               if (adv_d) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (adv_d) begin
                  bready_q <= 1'b0;
                  if (m_axi_bresp != 2'b00) error_q <= 1'b1;
                  if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q     <= nxt_d;
                     awaddr_q  <= awaddr_q + STEP;
                     wbeat_q   <= src_d[nxt_d*DW +: DW];
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WR_ADDR_DATA;
                  end
               end
            end
            S_DONE: begin
               if (!txn_en) begin
                  done_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rdata         = rvec_q;
   assign inst_done     = done_q;
   assign error         = error_q;
   assign timeout       = timeout_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wbeat_q;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_multi.sv
// Directed bench for axi_lite_master_multi with a small AXI-Lite
// slave model whose ready/response delays are set per scenario.
module tb_axi_lite_master_multi;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   mode;
   logic         txn_en;
   logic [31:0]  addra, addrb;
   logic [127:0] wvec, rvec;
   logic         inst_done, error, timeout;
   logic [31:0]  awaddr, wdata_b, araddr, srdata;
   logic [2:0]   awprot, arprot;
   logic [3:0]   wstrb;
   logic         awvalid, awready, wvalid, wready;
   logic         bvalid, bready, arvalid, arready;
   logic         rvalid, rready;
   logic [1:0]   bresp;

   int cmp = 0;
   int err = 0;

   // slave knobs (written only by the test process)
   logic        ar_en = 1'b1;
   int          aw_lat = 0, w_lat = 0, b_lat = 0;
   int          err_word = -1;
   logic [31:0] mem [0:63];

   // slave state and logs (written only by the slave process)
   int          aw_wait, w_wait, b_wait;
   logic        got_aw, got_w;
   int          bcount = 0, dup = 0, bad_bready = 0, bad_strb = 0;
   logic [31:0] aw_log[$], w_log[$], ar_log[$];

   always #5 clk = ~clk;

   axi_lite_master_multi #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .TXN_NUM(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .txn_en(txn_en),
      .off_mem_addra(addra), .off_mem_addrb(addrb),
      .wdata(wvec), .rdata(rvec), .inst_done(inst_done),
      .error(error), .timeout(timeout),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata_b), .m_axi_wstrb(wstrb),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(srdata), .m_axi_rresp(2'b00),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   assign arready = ar_en;
   assign awready = awvalid && (aw_wait >= aw_lat);
   assign wready  = wvalid && (w_wait >= w_lat);

   logic aw_hs, w_hs;
   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   always @(posedge clk) begin
      if (reset) begin
         rvalid <= 1'b0; srdata <= '0;
         bvalid <= 1'b0; bresp <= 2'b00;
         got_aw <= 1'b0; got_w <= 1'b0;
         aw_wait <= 0; w_wait <= 0; b_wait <= 0;
      end else begin
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            srdata <= mem[araddr[7:2]];
            ar_log.push_back(araddr);
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
         if (aw_hs) begin
            if (got_aw) dup <= dup + 1;
            got_aw <= 1'b1; aw_wait <= 0;
            aw_log.push_back(awaddr);
         end else if (awvalid) begin
            aw_wait <= aw_wait + 1;
         end
         if (w_hs) begin
            if (got_w) dup <= dup + 1;
            if (wstrb != 4'hF) bad_strb <= bad_strb + 1;
            got_w <= 1'b1; w_wait <= 0;
            w_log.push_back(wdata_b);
         end else if (wvalid) begin
            w_wait <= w_wait + 1;
         end
         if (bready && !(got_aw && got_w))
            bad_bready <= bad_bready + 1;
         if (bvalid && bready) begin
            bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            b_wait <= 0; bcount <= bcount + 1;
         end else if (!bvalid && (got_aw || aw_hs)
                      && (got_w || w_hs)) begin
            if (b_wait >= b_lat) begin
               bvalid <= 1'b1;
               bresp  <= (bcount == err_word) ? 2'b10 : 2'b00;
            end else begin
               b_wait <= b_wait + 1;
            end
         end
      end
   end

   task automatic start(input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [127:0] v);
      @(negedge clk);
      mode = m; addra = a; addrb = b; wvec = v; txn_en = 1'b1;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (inst_done !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; txn_en = 1'b0; mode = 2'b00;
      addra = '0; addrb = '0; wvec = '0;
      repeat (3) @(negedge clk);
      cmp++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
         err++;
         $display("FAIL reset_vr got %b want 00000",
                  {awvalid, wvalid, bready, arvalid, rready});
      end
      cmp++;
      if ({awaddr, araddr} !== 64'h0 || rvec !== 128'h0) begin
         err++;
         $display("FAIL reset_data got %h %h %h want 0",
                  awaddr, araddr, rvec);
      end
      cmp++;
      if ({inst_done, error, timeout} !== 3'b000) begin
         err++;
         $display("FAIL reset_flags got %b want 000",
                  {inst_done, error, timeout});
      end
      cmp++;
      if ({awprot, arprot, wstrb} !== {3'b000, 3'b000, 4'hF}) begin
         err++;
         $display("FAIL prot_strb got %h %h %h want 0 0 f",
                  awprot, arprot, wstrb);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      int c, b0;
      logic [31:0] exp_a, exp_d;
      b0 = aw_log.size();
      start(2'b10, 32'h10, 32'h0,
            {32'h4, 32'h3, 32'h2, 32'h1});
      @(negedge clk);
      addra = 32'hFFF0; wvec = '1; mode = 2'b01;
      wait_done(50, c);
      c++;
      cmp++;
      if (inst_done !== 1'b1 || c != 9) begin
         err++;
         $display("FAIL write_lat got %b/%0d want 1/9", inst_done, c);
      end
      cmp++;
      if (aw_log.size() - b0 != 4 || w_log.size() - b0 != 4) begin
         err++;
         $display("FAIL write_beats got %0d/%0d want 4/4",
                  aw_log.size() - b0, w_log.size() - b0);
      end else begin
         exp_a = 32'h10; exp_d = 32'h1;
         for (int k = 0; k < 4; k++) begin
            cmp++;
            if (aw_log[b0+k] !== exp_a || w_log[b0+k] !== exp_d) begin
               err++;
               $display("FAIL write_w%0d got %h:%h want %h:%h", k,
                        aw_log[b0+k], w_log[b0+k], exp_a, exp_d);
            end
            exp_a += 4; exp_d += 1;
         end
      end
      cmp++;
      if (error !== 1'b0 || timeout !== 1'b0) begin
         err++;
         $display("FAIL write_err got %b%b want 00", error, timeout);
      end
      txn_en = 1'b0;
      @(negedge clk);
      cmp++;
      if (inst_done !== 1'b0) begin
         err++;
         $display("FAIL write_done_clr got %b want 0", inst_done);
      end
   endtask

   task automatic test_load();
      int c, b0;
      for (int k = 0; k < 4; k++) mem[8+k] = 32'hA0 + k;
      b0 = ar_log.size();
      start(2'b01, 32'h0, 32'h20, '0);
      wait_done(50, c);
      cmp++;
      if (inst_done !== 1'b1 || c != 9) begin
         err++;
         $display("FAIL load_lat got %b/%0d want 1/9", inst_done, c);
      end
      cmp++;
      if (rvec !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
         err++;
         $display("FAIL load_rdata got %h want a3a2a1a0", rvec);
      end
      cmp++;
      if (ar_log.size() - b0 != 4) begin
         err++;
         $display("FAIL load_ar_n got %0d want 4", ar_log.size() - b0);
      end else begin
         for (int k = 0; k < 4; k++) begin
            cmp++;
            if (ar_log[b0+k] !== 32'h20 + 32'(4*k)) begin
               err++;
               $display("FAIL load_ar%0d got %h want %h", k,
                        ar_log[b0+k], 32'h20 + 32'(4*k));
            end
         end
      end
      txn_en = 1'b0;
      repeat (3) @(negedge clk);
      cmp++;
      if (rvec !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
         err++;
         $display("FAIL load_hold got %h want a3a2a1a0", rvec);
      end
   endtask

   task automatic test_copy();
      int c, ba, bw, br;
      mem[0] = 32'h11; mem[1] = 32'h22;
      mem[2] = 32'h33; mem[3] = 32'h44;
      ba = aw_log.size(); bw = w_log.size(); br = ar_log.size();
      start(2'b11, 32'h40, 32'h00, {4{32'hDEAD}});
      wait_done(80, c);
      cmp++;
      if (inst_done !== 1'b1 || c != 17) begin
         err++;
         $display("FAIL copy_lat got %b/%0d want 1/17", inst_done, c);
      end
      cmp++;
      if (ar_log.size() - br != 4 || aw_log.size() - ba != 4
          || w_log.size() - bw != 4) begin
         err++;
         $display("FAIL copy_beats got %0d/%0d/%0d want 4/4/4",
                  ar_log.size() - br, aw_log.size() - ba,
                  w_log.size() - bw);
      end else begin
         for (int k = 0; k < 4; k++) begin
            cmp++;
            if (aw_log[ba+k] !== 32'h40 + 32'(4*k)
                || w_log[bw+k] !== 32'(17 * (k + 1))) begin
               err++;
               $display("FAIL copy_w%0d got %h:%h want %h:%h", k,
                        aw_log[ba+k], w_log[bw+k],
                        32'h40 + 32'(4*k), 32'(17 * (k + 1)));
            end
         end
      end
      cmp++;
      if (rvec !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
         err++;
         $display("FAIL copy_rdata got %h want 44332211", rvec);
      end
      txn_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_skew();
      int c, b0, d0, bb0, bc0;
      for (int cfg = 0; cfg < 2; cfg++) begin
         w_lat  = (cfg == 0) ? 0 : 2;
         aw_lat = (cfg == 0) ? 3 : 0;
         b_lat  = (cfg == 0) ? 4 : 1;
         b0 = aw_log.size(); d0 = dup;
         bb0 = bad_bready; bc0 = bcount;
         start(2'b10, 32'h100 + 32'(cfg * 64), 32'h0,
               {32'h55000004, 32'h55000003,
                32'h55000002, 32'h55000001});
         wait_done(200, c);
         cmp++;
         if (inst_done !== 1'b1 || bcount - bc0 != 4
             || w_log.size() - b0 != 4) begin
            err++;
            $display("FAIL skew%0d_n got %b/%0d/%0d want 1/4/4", cfg,
                     inst_done, bcount - bc0, w_log.size() - b0);
         end else begin
            for (int k = 0; k < 4; k++) begin
               cmp++;
               if (aw_log[b0+k] !== 32'h100 + 32'(cfg*64 + 4*k)
                   || w_log[b0+k] !== 32'h55000001 + 32'(k)) begin
                  err++;
                  $display("FAIL skew%0d_w%0d got %h:%h", cfg, k,
                           aw_log[b0+k], w_log[b0+k]);
               end
            end
         end
         cmp++;
         if (dup != d0 || bad_bready != bb0 || bad_strb != 0) begin
            err++;
            $display("FAIL skew%0d_proto got %0d/%0d/%0d want 0/0/0",
                     cfg, dup - d0, bad_bready - bb0, bad_strb);
         end
         txn_en = 1'b0;
         @(negedge clk);
      end
      w_lat = 0; aw_lat = 0; b_lat = 0;
   endtask

   task automatic test_bresp_err();
      int c, bc0;
      bc0 = bcount;
      err_word = bc0 + 2;
      start(2'b10, 32'h80, 32'h0, {4{32'h77}});
      wait_done(50, c);
      cmp++;
      if ({inst_done, error, timeout} !== 3'b110
          || bcount - bc0 != 4) begin
         err++;
         $display("FAIL bresp got %b/%0d want 110/4",
                  {inst_done, error, timeout}, bcount - bc0);
      end
      err_word = -1;
      txn_en = 1'b0;
      repeat (2) @(negedge clk);
      cmp++;
      if (error !== 1'b1) begin
         err++;
         $display("FAIL bresp_sticky got %b want 1", error);
      end
      start(2'b10, 32'h80, 32'h0, {4{32'h78}});
      @(negedge clk);
      cmp++;
      if (error !== 1'b0) begin
         err++;
         $display("FAIL bresp_clear got %b want 0", error);
      end
      wait_done(50, c);
      txn_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode_idle();
      int c, b0, r0;
      b0 = aw_log.size(); r0 = ar_log.size();
      start(2'b00, 32'h0, 32'h0, '0);
      wait_done(10, c);
      cmp++;
      if (inst_done !== 1'b1 || c != 1) begin
         err++;
         $display("FAIL idle_done got %b/%0d want 1/1", inst_done, c);
      end
      cmp++;
      if (aw_log.size() != b0 || ar_log.size() != r0) begin
         err++;
         $display("FAIL idle_bus got %0d/%0d want 0/0",
                  aw_log.size() - b0, ar_log.size() - r0);
      end
      txn_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int c, hi;
      ar_en = 1'b0;
      start(2'b01, 32'h0, 32'h0, '0);
      c = 0; hi = 0;
      while (inst_done !== 1'b1 && c < 40) begin
         @(negedge clk);
         c++;
         if (arvalid) hi++;
      end
      cmp++;
      if ({inst_done, timeout, error, arvalid} !== 4'b1110
          || hi != 16) begin
         err++;
         $display("FAIL timeout got %b/%0d want 1110/16",
                  {inst_done, timeout, error, arvalid}, hi);
      end
      ar_en = 1'b1;
      txn_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int b0;
      aw_lat = 8; w_lat = 8;
      b0 = aw_log.size();
      start(2'b10, 32'h200, 32'h0, {4{32'h99}});
      repeat (3) @(negedge clk);
      cmp++;
      if (awvalid !== 1'b1) begin
         err++;
         $display("FAIL mid_busy got %b want 1", awvalid);
      end
      reset = 1'b1; txn_en = 1'b0;
      @(negedge clk);
      cmp++;
      if ({awvalid, wvalid, bready, arvalid, rready,
           inst_done, error, timeout} !== 8'h00
          || {awaddr, wdata_b, rvec} !== '0) begin
         err++;
         $display("FAIL mid_reset got %b %h %h %h want 0",
                  {awvalid, wvalid, bready, arvalid, rready,
                   inst_done, error, timeout}, awaddr, wdata_b, rvec);
      end
      reset = 1'b0;
      repeat (10) @(negedge clk);
      cmp++;
      if (aw_log.size() != b0 || awvalid !== 1'b0) begin
         err++;
         $display("FAIL mid_after got %0d/%b want 0/0",
                  aw_log.size() - b0, awvalid);
      end
      aw_lat = 0; w_lat = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      test_reset();
      test_write();
      test_load();
      test_copy();
      test_skew();
      test_bresp_err();
      test_mode_idle();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp, err);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_multi.md
Name: axi_lite_master_multi

Overview:
- Parametrised AXI4-Lite master that moves a TXN_NUM-word vector between the unified-buffer datapath and off-chip memory (OFF_MEM slave).
- Next generation of the fixed 4-word, 32-bit LOAD_DATA/WRITE_DATA master.
- Adds configurable width/depth, a COPY mode (read from addrb, then write to addra), sticky response-error capture and a handshake timeout.
- Driven by the control unit via the txn_en / inst_done instruction handshake.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (32 or 64)
TXN_NUM, 4, words per instruction (1..64)
TIMEOUT_CYCLES, 1024, max cycles waiting on any single slave handshake before abort

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mode  in  2  00 IDLE, 01 LOAD_DATA, 10 WRITE_DATA, 11 COPY
txn_en  in  1  instruction request level
off_mem_addra  in  ADDR_WIDTH  write base address
off_mem_addrb  in  ADDR_WIDTH  read base address
wdata  in  DATA_WIDTH*TXN_NUM  write vector; word k = [k*DATA_WIDTH +: DATA_WIDTH]
rdata  out  DATA_WIDTH*TXN_NUM  read vector, same packing
inst_done  out  1  instruction complete
error  out  1  sticky error for current instruction
timeout  out  1  sticky timeout flag for current instruction
m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master channel, widths from parameters

Behaviour:
- Reset (clk edge with reset=1): all valid/ready outputs 0, addresses 0, rdata 0, inst_done/error/timeout 0, state IDLE, word counter 0. Reset mid-burst aborts immediately; no handshake completed afterwards.
- awprot = arprot = 3'b000; wstrb all ones.
- Start: in IDLE with txn_en=1, inst_done=0 and mode!=00:
  - latch mode, both base addresses and the wdata vector;
  - clear error/timeout and the counter.
  - mode=00 with txn_en: inst_done asserts next cycle, no bus activity.
- Word k address = base + k*(DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE.
- LOAD_DATA (RD_ADDR → RD_DATA):
  - arvalid held until arready; then rready held until rvalid.
  - rdata word k captured on the rvalid&rready cycle.
  - Counter increments; next word or DONE after word TXN_NUM-1.
- WRITE_DATA (WR_ADDR_DATA → WR_RESP):
  - awvalid and wvalid rise together; each drops independently on its own ready.
  - Same-cycle awready/wready allowed; order between them is free.
  - Once both have handshaked, bready is held until bvalid.
  - One outstanding transaction at a time.
- COPY: full LOAD of TXN_NUM words from addrb into the rdata register, then a WRITE of that captured vector (not the wdata input) to addra.
- rdata output updates only in LOAD/COPY; it holds between instructions.
- Response error: rresp or bresp != 2'b00 sets error. The instruction continues to completion.
- Timeout:
  - Per-handshake counter resets on every state entry.
  - Reaching TIMEOUT_CYCLES sets timeout and error, drops all valid/ready outputs and jumps to DONE.
- DONE: inst_done=1, held while txn_en=1. When txn_en=0, inst_done clears next cycle and the block returns to IDLE. A new start needs inst_done=0.
- Minimum latency with an always-ready slave returning a response the cycle after:
  - 2 cycles per word (address and data/response phases);
  - inst_done at start + 2*TXN_NUM + 1 (LOAD/WRITE), start + 4*TXN_NUM + 1 (COPY).
- Changes to mode/addresses/wdata during an instruction are ignored.

Test Plan:
- Reset, then WRITE_DATA, addra=0x10, TXN_NUM=4, wdata={32'h4,32'h3,32'h2,32'h1} -> AW addresses 0x10,0x14,0x18,0x1C with data 1,2,3,4; inst_done high; error=0; inst_done low one cycle after txn_en drops.
- LOAD_DATA, addrb=0x20, memory words 0xA0..0xA3 -> rdata={A3,A2,A1,A0}; exactly 4 AR handshakes.
- COPY, addrb=0x00 → addra=0x40 -> 4 reads, then 4 writes to 0x40..0x4C carrying the read values; wdata input (0xDEAD) is never driven on the bus.
- Slave with random awready/wready skew (wready 3 cycles before awready) and delayed bvalid -> no duplicate or dropped beats; bready asserts only after both handshakes.
- Slave returns bresp=2'b10 on word 2 -> error=1, all 4 writes still performed, inst_done=1; error clears at the next start.
- Slave never asserts arready, TIMEOUT_CYCLES=16 -> arvalid drops and timeout=error=inst_done=1 after 16 cycles. A separate run asserting reset mid-write -> all outputs 0 on the next edge.
